// File: rtl/uart_rx_fifo.sv
// Receive-to-transmit byte buffer: queues bytes strobed in from a UART receiver
// and hands them one at a time to a transmitter over a start/busy handshake.
module uart_rx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic                  tx_busy,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  overflow,
   input  logic                  clr_overflow
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_e;

   state_e                state_q, state_d;
   logic                  wait_q, wait_d;
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  empty_q, full_q;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            mem [DEPTH];

   logic pop, push, drop;

   // A pop frees a slot on the same edge, so a full buffer still accepts a byte then.
   assign pop  = (state_q == S_IDLE) && enable && !empty_q && !tx_busy;
   assign push = rx_valid && (!full_q || pop);
   assign drop = rx_valid && full_q && !pop;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         S_IDLE: begin
            if (pop) state_d = S_START;
         end
         S_START: begin
            state_d = S_WAIT_BUSY;
            wait_d  = 1'b0;
         end
         S_WAIT_BUSY: begin
            // A transmitter that never raises busy is treated as having sent the byte.
            if (tx_busy)     state_d = S_WAIT_DONE;
            else if (wait_q) state_d = S_IDLE;
            else             wait_d  = 1'b1;
         end
         S_WAIT_DONE: begin
            if (!tx_busy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wptr_d     = push ? wptr_q + PTR_ONE : wptr_q;
      rptr_d     = pop  ? rptr_q + PTR_ONE : rptr_q;
      tx_data_d  = pop  ? mem[rptr_q] : tx_data_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + COUNT_ONE;
         2'b01:   count_d = count_q - COUNT_ONE;
         default: count_d = count_q;
      endcase
      if (drop)              overflow_d = 1'b1;
      else if (clr_overflow) overflow_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wait_q     <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         tx_data_q  <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         empty_q    <= (count_d == '0);
         full_q     <= (count_d == COUNT_FULL);
         tx_data_q  <= tx_data_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: the storage array is not reset; the count and pointers alone define which slots are valid.
   always_ff @(posedge clk) begin
      if (rst_n && push) mem[wptr_q] <= rx_data;
   end

   assign tx_start   = (state_q == S_START);
   assign tx_data    = tx_data_q;
   assign fifo_count = count_q;
   assign fifo_empty = empty_q;
   assign fifo_full  = full_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the buffer and drain timeline.
module tb_uart_rx_fifo;

   localparam int DL    = 4;
   localparam int DEPTH = 1 << DL;

   logic          clk = 1'b0;
   logic          rst_n, enable, rx_valid, tx_busy, clr_overflow;
   logic [7:0]    rx_data;
   logic          tx_start, fifo_empty, fifo_full, overflow;
   logic [7:0]    tx_data;
   logic [DL:0]   fifo_count;

   int total = 0;
   int bad   = 0;

   logic [7:0] q[$];
   logic [7:0] dut_sent[$];
   logic [7:0] m_txd;
   bit         m_ovf, m_start, in_flight, seen;
   int         since;

   bit auto_busy, rand_busy;
   int blen, bdelay, b_wait, b_left;

   uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .tx_busy      (tx_busy),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .fifo_count   (fifo_count),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: update the model from the inputs seen at the edge, check, then drive the transmitter.
   task automatic cycle();
      bit pop, was_full, drop;
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         m_ovf = 0; m_txd = 8'h00; m_start = 0;
         in_flight = 0; seen = 0; since = 0;
      end else begin
         pop      = !in_flight && enable && (q.size() > 0) && !tx_busy;
         was_full = (q.size() == DEPTH);
         // Byte in flight: start cycle, then a two-edge window for busy, then until busy drops.
         if (in_flight) begin
            since++;
            if (seen) begin
               if (!tx_busy) in_flight = 0;
            end else if (since >= 2) begin
               if (tx_busy)          seen = 1;
               else if (since == 3)  in_flight = 0;
            end
         end
         if (pop) begin
            m_txd = q.pop_front();
            in_flight = 1; since = 0; seen = 0;
         end
         drop = rx_valid && was_full && !pop;
         if (rx_valid && !drop) q.push_back(rx_data);
         if (drop)              m_ovf = 1;
         else if (clr_overflow) m_ovf = 0;
         m_start = pop;
      end
      #1;
      chk("tx_start",   tx_start,   m_start);
      chk("tx_data",    tx_data,    m_txd);
      chk("fifo_count", fifo_count, q.size());
      chk("fifo_empty", fifo_empty, q.size() == 0);
      chk("fifo_full",  fifo_full,  q.size() == DEPTH);
      chk("overflow",   overflow,   m_ovf);
      if (tx_start === 1'b1) dut_sent.push_back(tx_data);
      if (auto_busy) begin
         if (tx_start === 1'b1) begin
            b_wait = rand_busy ? int'($urandom_range(0, 3)) : bdelay;
            b_left = rand_busy ? int'($urandom_range(0, 4)) : blen;
         end
         if (b_wait > 0) begin
            b_wait--; tx_busy = 1'b0;
         end else if (b_left > 0) begin
            b_left--; tx_busy = 1'b1;
         end else begin
            tx_busy = 1'b0;
         end
      end
   endtask

   initial begin
      int s0, nff;
      logic [7:0] wrap_exp[40];

      rst_n = 1'b0; enable = 1'b1; rx_valid = 1'b1; rx_data = 8'h3C;
      tx_busy = 1'b0; clr_overflow = 1'b0;
      auto_busy = 0; rand_busy = 0; blen = 0; bdelay = 0; b_wait = 0; b_left = 0;
      m_txd = 8'h00; m_ovf = 0; m_start = 0; in_flight = 0; seen = 0; since = 0;

      // Reset with rx_valid asserted: strobes must be ignored.
      repeat (3) cycle();
      chk("rst_empty", fifo_empty, 1'b1);
      chk("rst_count", fifo_count, 0);
      chk("rst_txd",   tx_data,    8'h00);
      rst_n = 1'b1; rx_valid = 1'b0;
      cycle();
      chk("rst_release_start", tx_start, 1'b0);

      // Single byte with a 10-cycle transmitter.
      auto_busy = 1; blen = 10; bdelay = 0;
      rx_valid = 1'b1; rx_data = 8'hA5;
      cycle();
      chk("lat_empty", fifo_empty, 1'b0);
      chk("lat_count", fifo_count, 1);
      rx_valid = 1'b0;
      cycle();
      chk("lat_start", tx_start, 1'b1);
      chk("lat_data",  tx_data,  8'hA5);
      chk("lat_count0", fifo_count, 0);
      cycle();
      chk("lat_one_cycle", tx_start, 1'b0);
      repeat (15) cycle();

      // Burst of 16 with busy held, then an overflowing byte and a clear.
      auto_busy = 0; tx_busy = 1'b1;
      s0 = dut_sent.size();
      for (int i = 0; i < 16; i++) begin
         rx_valid = 1'b1; rx_data = 8'(i);
         cycle();
      end
      chk("burst_full",  fifo_full,  1'b1);
      chk("burst_count", fifo_count, 16);
      rx_data = 8'hFF;
      cycle();
      chk("ovf_set",   overflow,   1'b1);
      chk("ovf_count", fifo_count, 16);
      rx_valid = 1'b0; clr_overflow = 1'b1;
      cycle();
      chk("ovf_clr", overflow, 1'b0);
      clr_overflow = 1'b0;

      // Full buffer: write on the same edge as the pop is accepted.
      tx_busy = 1'b0; rx_valid = 1'b1; rx_data = 8'h10;
      auto_busy = 1; blen = 3; bdelay = 0;
      cycle();
      chk("fullpop_count", fifo_count, 16);
      chk("fullpop_start", tx_start,   1'b1);
      chk("fullpop_ovf",   overflow,   1'b0);
      rx_valid = 1'b0;
      repeat (120) cycle();
      chk("burst_frames", dut_sent.size() - s0, 17);
      nff = 0;
      for (int i = 0; i < 17 && s0 + i < dut_sent.size(); i++) begin
         chk("burst_order", dut_sent[s0 + i], i);
         if (dut_sent[s0 + i] == 8'hFF) nff++;
      end
      chk("ff_never_sent", nff, 0);

      // Forty bytes through the pointers with a silent transmitter: every frame times out.
      auto_busy = 0; tx_busy = 1'b0;
      s0 = dut_sent.size();
      for (int i = 0; i < 40; i++) begin
         wrap_exp[i] = 8'($urandom);
         rx_valid = 1'b1; rx_data = wrap_exp[i];
         cycle();
         rx_valid = 1'b0;
         repeat (3) cycle();
      end
      repeat (24) cycle();
      chk("wrap_frames", dut_sent.size() - s0, 40);
      for (int i = 0; i < 40 && s0 + i < dut_sent.size(); i++)
         chk("wrap_order", dut_sent[s0 + i], wrap_exp[i]);

      // Reset while a frame is in WAIT_DONE with bytes still queued.
      enable = 1'b0; auto_busy = 1; blen = 20; bdelay = 0;
      for (int i = 0; i < 5; i++) begin
         rx_valid = 1'b1; rx_data = 8'hC0 + 8'(i);
         cycle();
      end
      rx_valid = 1'b0;
      chk("mid_count5", fifo_count, 5);
      enable = 1'b1;
      repeat (6) cycle();
      rst_n = 1'b0;
      cycle();
      chk("mid_count", fifo_count, 0);
      chk("mid_empty", fifo_empty, 1'b1);
      chk("mid_start", tx_start,   1'b0);
      rst_n = 1'b1;
      s0 = dut_sent.size();
      repeat (30) cycle();
      chk("mid_no_start", dut_sent.size() - s0, 0);
      rx_valid = 1'b1; rx_data = 8'h5A;
      cycle();
      rx_valid = 1'b0;
      repeat (4) cycle();
      chk("mid_new_frame", dut_sent.size() - s0, 1);

      // Random traffic with a randomly timed transmitter.
      rand_busy = 1;
      for (int i = 0; i < 500; i++) begin
         rx_valid     = ($urandom_range(0, 2) == 0);
         rx_data      = 8'($urandom);
         enable       = ($urandom_range(0, 7) != 0);
         clr_overflow = ($urandom_range(0, 15) == 0);
         rst_n        = ($urandom_range(0, 199) != 0);
         cycle();
      end
      rst_n = 1'b1; rx_valid = 1'b0; enable = 1'b1; clr_overflow = 1'b0;
      repeat (200) cycle();
      chk("final_empty", fifo_empty, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes; legal range 2..8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 enable  input  1  drain enable; 0 = hold queued bytes, no new tx_start.
REQ-005 rx_valid  input  1  one-cycle strobe from receiver, byte on rx_data.
REQ-006 rx_data  input  8  received byte, valid when rx_valid=1.
REQ-007 tx_busy  input  1  transmitter busy, high while frame shifts out.
REQ-008 tx_start  output  1  one-cycle start strobe to transmitter.
REQ-009 tx_data  output  8  byte for transmitter, registered, stable from tx_start until the next tx_start.
REQ-010 fifo_count  output  DEPTH_LOG2+1  bytes currently stored, 0..2**DEPTH_LOG2.
REQ-011 fifo_empty / fifo_full  output  1 each  count==0 / count==depth.
REQ-012 overflow  output  1  sticky, set when a byte is dropped.
REQ-013 clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-014 Storage: circular buffer, DEPTH_LOG2-bit write/read pointers, wrap modulo depth, no reserved slot.
REQ-015 Write: rx_valid=1 and (not full, or pop in same cycle) -> store rx_data at wptr, wptr+1.
REQ-016 Drop: rx_valid=1, full, no pop that cycle -> byte discarded, pointers/count unchanged, overflow=1 next cycle.
REQ-017 Count: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop; never exceeds depth or underflows.
REQ-018 Drain FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE -> START when enable=1, not empty, tx_busy=0; that edge pops: tx_data<=mem[rptr], rptr+1, count-1.
REQ-020 START: tx_start=1 exactly this one cycle; -> WAIT_BUSY.
REQ-021 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; 2 cycles in WAIT_BUSY without tx_busy -> IDLE (timeout guard, byte considered sent).
REQ-022 WAIT_DONE: tx_busy=0 -> IDLE; at most one byte in flight at any time.
REQ-023 enable=0 only blocks IDLE->START; a transfer already in START/WAIT_* completes.
REQ-024 Latency: rx_valid at edge k into empty FIFO, FSM IDLE, enable=1, tx_busy=0 -> fifo_empty=0 after edge k, tx_start=1 after edge k+1, for one cycle.
REQ-025 Ordering: bytes leave strictly in arrival order; no duplication, no loss except REQ-016 drops.
REQ-026 overflow: set wins over clr_overflow in the same cycle; otherwise clr_overflow=1 -> 0 next cycle.
REQ-027 Flags fifo_empty/fifo_full/fifo_count registered-consistent: all reflect the same post-edge count.

Reset
REQ-028 rst_n=0 at an edge: pointers=0, count=0, FSM=IDLE, tx_start=0, tx_data=8'h00, overflow=0, fifo_empty=1, fifo_full=0.
REQ-029 Reset mid-transfer or with data queued discards all contents; no tx_start in the cycle after reset release.
REQ-030 rx_valid during reset ignored.

Verification
REQ-031 Single byte: rx_data=8'hA5 strobe, tx_busy model 10 cycles -> tx_start 1 cycle after write, tx_data=8'hA5, count 1->0, empty.
REQ-032 Burst: 16 bytes 0x00..0x0F back-to-back, tx_busy held 1 -> full=1, count=16; release busy -> 0x00..0x0F out in order, one tx_start per frame.
REQ-033 Overflow: fill 16, 17th byte 0xFF with no pop -> dropped, overflow=1, count=16; clr_overflow -> overflow=0; 0xFF never transmitted.
REQ-034 Full + simultaneous write/pop: full, rx_valid on IDLE->START pop edge -> accepted, count stays 16, overflow stays 0.
REQ-035 Wrap and timeout: 40 bytes through pointers (wrap twice), tx_busy never asserted -> each byte exits via 2-cycle timeout, order intact.
REQ-036 Reset mid-operation: 5 queued, rst_n=0 during WAIT_DONE -> count=0, empty=1, tx_start=0, no further tx_start until new rx_valid.
